sys_console: RTL and testbench
==============================

SYS_CONSOLE -- requirements
Module: sys_console

Interface
REQ-001 Parameter: DEPTH, default 4, the request FIFO depth in entries (power of two, at least 2).
REQ-002 Port: clk, input, 1 bit, the only clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1 bit, reset; synchronous and active-high.
REQ-004 Port: req_valid, input, 1 bit, a syscall request is presented.
REQ-005 Port: req_ready, output, 1 bit, the block accepts the request this cycle.
REQ-006 Port: req_code, input, 32 bits, service code (the $v0 value).
REQ-007 Port: req_arg, input, 32 bits, argument (the $a0 value).
REQ-008 Port: ch_valid, output, 1 bit, a character is presented downstream.
REQ-009 Port: ch_data, output, 8 bits, ASCII character.
REQ-010 Port: ch_ready, input, 1 bit, downstream accepts the character.
REQ-011 Port: halted, output, 1 bit, a halt service has completed; the block is quiescent.
REQ-012 Port: busy, output, 1 bit, FIFO non-empty or state not IDLE.
REQ-013 Port: err_count, output, 8 bits, count of unsupported service codes.

Function
REQ-014 Accept: a request transfers on a rising edge when req_valid and req_ready are both high; {code, arg} is written to the FIFO tail.
REQ-015 req_ready is high only when the FIFO is not full, halt_seen is low and halted is low; it is combinational from state only and never depends on req_valid.
REQ-016 A pop on the same edge does not make a full FIFO accept a request.
REQ-017 halt_seen is set on the edge that accepts code 10 and stays set until reset.
REQ-018 State machine states: IDLE, LOAD, EMIT, HALT.
REQ-019 IDLE: if the FIFO is non-empty, pop the head into the working registers and go to LOAD; otherwise stay in IDLE.
REQ-020 LOAD, code 1: build an 11-character sequence "0x", then 8 lowercase hex digits of arg (MSB nibble first), then 0x0A; go to EMIT.
REQ-021 LOAD, code 11: build a 1-character sequence arg[7:0]; go to EMIT.
REQ-022 LOAD, code 10: go to HALT.
REQ-023 LOAD, any other code: increment err_count, saturating at 255; go to IDLE; emit nothing.
REQ-024 EMIT: ch_valid is high; ch_data and ch_valid hold stable until ch_ready is high.
REQ-025 On each transfer (ch_valid and ch_ready high) EMIT advances to the next character.
REQ-026 After the last character transfers, go to IDLE.
REQ-027 HALT: halted is high from the edge after entering HALT and is held until reset; no further pops occur.
REQ-028 Latency: a request accepted on edge k, with the FIFO empty and state IDLE, is popped on edge k+1 and reaches LOAD.
REQ-029 That request's first ch_valid is high after edge k+2.
REQ-030 Throughput: with ch_ready held high, one character transfers per cycle.
REQ-031 After a sequence ends there is a 2-cycle gap (IDLE, LOAD) before the next sequence.
REQ-032 Ordering: sequences are emitted in acceptance order with no interleaving.
REQ-033 FIFO pointers wrap modulo DEPTH.
REQ-034 Full and empty are distinguished by an extra pointer bit.
REQ-035 busy is low only in IDLE with the FIFO empty.
REQ-036 busy is high in HALT.

Reset
REQ-037 When rst is high at a rising edge: FIFO empty, state IDLE, ch_valid 0, ch_data 0x00, halted 0, halt_seen 0, err_count 0; req_ready is 1 after that edge.
REQ-038 Reset mid-EMIT or mid-HALT abandons the in-flight sequence and all queued entries; no character is presented after the reset edge.
REQ-039 rst has priority over every simultaneous accept and transfer.

Verification
REQ-040 Print int: code 1, arg 0x00C0FFEE, ch_ready=1 -> characters 0x30 0x78 0x30 0x30 0x63 0x30 0x66 0x66 0x65 0x65 0x0A on consecutive cycles; first ch_valid 2 edges after accept.
REQ-041 Backpressure: code 11, arg 0x41, ch_ready=0 for 5 cycles then 1 -> ch_valid high with ch_data 0x41 stable all 5 cycles; exactly one transfer.
REQ-042 Full FIFO: ch_ready=0, push 5 code-11 requests with DEPTH=4 -> first popped into EMIT, then 4 queued, req_ready 0; after ch_ready=1, all 5 characters are emitted in order.
REQ-043 Halt ordering: code 11 'A', code 10, code 11 'B' -> 'A' emitted; req_ready drops after the code-10 accept; 'B' never accepted; halted=1; busy=1.
REQ-044 Error saturation: 260 requests with code 7 -> no ch_valid; err_count reads 255.
REQ-045 Reset mid-emit: rst for 1 cycle during character 4 of a code-1 sequence -> ch_valid 0 and FIFO empty the next cycle; a new code 11, arg 0x5A emits 0x5A only.

Source files
------------

// File: rtl/sys_console.sv
// rtl/sys_console.sv - syscall console: request FIFO feeding a character emitter
//
// Purpose: accepts {code, arg} syscall requests into a DEPTH-entry FIFO and
// turns each into a character stream. Code 1 prints arg as "0x" + 8 lowercase
// hex digits + newline, code 11 prints arg[7:0], code 10 halts, and any other
// code bumps a saturating error counter.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake; req_code/req_arg carry the request
//   ch_valid/ch_ready    character handshake; ch_data carries the character
//   halted               halt service completed, block quiescent
//   busy                 FIFO non-empty or state machine not IDLE
//   err_count            saturating count of unsupported service codes
module sys_console #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_code,
  input  logic [31:0] req_arg,
  output logic        ch_valid,
  output logic [7:0]  ch_data,
  input  logic        ch_ready,
  output logic        halted,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, HALT} state_t;

  state_t      state, state_nx;
  logic [63:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;   // extra MSB separates full from empty
  logic        empty, full, accept, pop, xfer, last_char;
  logic        halt_seen, is_print;
  logic [31:0] code_r, arg_r;
  logic [3:0]  idx;
  logic [3:0]  nib;
  logic [7:0]  hex_char;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Depends on registered state only, so a same-edge pop never frees a slot early.
  assign req_ready = !full && !halt_seen && !halted;
  assign accept    = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign ch_valid  = (state == EMIT);
  assign xfer      = ch_valid && ch_ready;
  assign last_char = is_print ? (idx == 4'd10) : 1'b1;
  assign busy      = !empty || (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!empty) state_nx = LOAD;
      LOAD: begin
        if (code_r == 32'd1 || code_r == 32'd11) state_nx = EMIT;
        else if (code_r == 32'd10)               state_nx = HALT;
        else                                     state_nx = IDLE;
      end
      EMIT: if (xfer && last_char) state_nx = IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= {req_code, req_arg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
      err_count <= 8'd0;
      code_r    <= 32'd0;
      arg_r     <= 32'd0;
      is_print  <= 1'b0;
      idx       <= 4'd0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (req_code == 32'd10) halt_seen <= 1'b1;
      end
      if (pop) begin
        {code_r, arg_r} <= mem[rd_ptr[AW-1:0]];
        rd_ptr          <= rd_ptr + 1'b1;
      end
      if (state == LOAD) begin
        idx      <= 4'd0;
        is_print <= (code_r == 32'd1);
        if (code_r != 32'd1 && code_r != 32'd10 && code_r != 32'd11 && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
      if (xfer) idx <= idx + 4'd1;
      if (state == HALT) halted <= 1'b1;
    end
  end

  // Hex digit for positions 2..9, most significant nibble first.
  always_comb begin
    nib = 4'h0;
    case (idx)
      4'd2: nib = arg_r[31:28];
      4'd3: nib = arg_r[27:24];
      4'd4: nib = arg_r[23:20];
      4'd5: nib = arg_r[19:16];
      4'd6: nib = arg_r[15:12];
      4'd7: nib = arg_r[11:8];
      4'd8: nib = arg_r[7:4];
      4'd9: nib = arg_r[3:0];
      default: nib = 4'h0;
    endcase
    hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  end

  always_comb begin
    ch_data = 8'h00;
    if (state == EMIT) begin
      if (!is_print) ch_data = arg_r[7:0];
      else begin
        case (idx)
          4'd0:    ch_data = 8'h30;
          4'd1:    ch_data = 8'h78;
          4'd10:   ch_data = 8'h0A;
          default: ch_data = hex_char;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_console.sv
// tb/tb_sys_console.sv - directed self-checking bench for sys_console
module tb_sys_console;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_code;
  logic [31:0] req_arg;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        halted;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  sys_console #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_code(req_code), .req_arg(req_arg),
    .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .halted(halted), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_char(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!ch_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(ch_valid), 32'd1);
    chk({tag, "_data"}, 32'(ch_data), 32'(exp));
    tick();
  endtask

  logic [7:0] print_exp [11];
  logic [7:0] last_ch;
  int acc, seen, cyc;

  initial begin
    print_exp = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h63, 8'h30, 8'h66, 8'h66, 8'h65, 8'h65, 8'h0A};
    rst = 1'b1; req_valid = 1'b0; req_code = 32'd0; req_arg = 32'd0; ch_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ch_valid", 32'(ch_valid), 32'd0);
    chk("rst_ch_data", 32'(ch_data), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);

    // Print int with exact latency and back-to-back characters.
    ch_ready = 1'b1;
    req_code = 32'd1; req_arg = 32'h00C0FFEE; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("pr_lat_k", 32'(ch_valid), 32'd0);
    chk("pr_busy", 32'(busy), 32'd1);
    tick();
    chk("pr_lat_k1", 32'(ch_valid), 32'd0);
    tick();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("pr_valid%0d", i), 32'(ch_valid), 32'd1);
      chk($sformatf("pr_data%0d", i), 32'(ch_data), 32'(print_exp[i]));
      tick();
    end
    chk("pr_end_valid", 32'(ch_valid), 32'd0);
    chk("pr_end_busy", 32'(busy), 32'd0);

    // Backpressure: character held stable, exactly one transfer.
    ch_ready = 1'b0;
    req_code = 32'd11; req_arg = 32'h41; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid%0d", i), 32'(ch_valid), 32'd1);
      chk($sformatf("bp_data%0d", i), 32'(ch_data), 32'h41);
      tick();
    end
    ch_ready = 1'b1;
    chk("bp_xfer_data", 32'(ch_data), 32'h41);
    tick();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ch_valid) seen++;
      tick();
    end
    chk("bp_one_xfer", 32'(seen), 32'd0);

    // Full FIFO: one in EMIT plus four queued, then drain in order.
    ch_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_code = 32'd11; req_arg = 32'h61 + 32'(i); req_valid = 1'b1;
      chk($sformatf("full_rdy%0d", i), 32'(req_ready), 32'd1);
      tick();
    end
    req_arg = 32'h7A;
    chk("full_rdy_low", 32'(req_ready), 32'd0);
    tick(); tick();
    chk("full_rdy_held", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    chk("full_head_valid", 32'(ch_valid), 32'd1);
    chk("full_head_data", 32'(ch_data), 32'h61);
    ch_ready = 1'b1;
    for (int i = 0; i < 5; i++) wait_char($sformatf("full_ch%0d", i), 8'h61 + 8'(i));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ch_valid) seen++;
      tick();
    end
    chk("full_no_extra", 32'(seen), 32'd0);

    // Error saturation.
    req_code = 32'd7; req_arg = 32'd0; req_valid = 1'b1;
    acc = 0; seen = 0; cyc = 0;
    while (acc < 260 && cyc < 3000) begin
      if (req_ready) acc++;
      if (ch_valid) seen++;
      tick();
      cyc++;
    end
    req_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      if (ch_valid) seen++;
      tick();
      cyc++;
    end
    chk("err_accepts", 32'(acc), 32'd260);
    chk("err_no_chars", 32'(seen), 32'd0);
    chk("err_sat", 32'(err_count), 32'd255);
    chk("err_idle", 32'(busy), 32'd0);

    // Reset during character 4 of a print sequence.
    req_code = 32'd1; req_arg = 32'h12345678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("rme_char4", 32'(ch_data), 32'h32);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rme_valid", 32'(ch_valid), 32'd0);
    chk("rme_busy", 32'(busy), 32'd0);
    chk("rme_ready", 32'(req_ready), 32'd1);
    chk("rme_err", 32'(err_count), 32'd0);
    req_code = 32'd11; req_arg = 32'h5A; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_char("rme_new", 8'h5A);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ch_valid) seen++;
      tick();
    end
    chk("rme_only_one", 32'(seen), 32'd0);

    // Halt ordering.
    req_code = 32'd11; req_arg = 32'h41; req_valid = 1'b1;
    chk("halt_rdy_a", 32'(req_ready), 32'd1);
    tick();
    req_code = 32'd10; req_arg = 32'd0;
    chk("halt_rdy_10", 32'(req_ready), 32'd1);
    tick();
    req_code = 32'd11; req_arg = 32'h42;
    chk("halt_rdy_drop", 32'(req_ready), 32'd0);
    acc = 0; seen = 0; last_ch = 8'h00;
    for (int i = 0; i < 30; i++) begin
      if (req_valid && req_ready) acc++;
      if (ch_valid) begin
        seen++;
        last_ch = ch_data;
      end
      tick();
    end
    req_valid = 1'b0;
    chk("halt_b_blocked", 32'(acc), 32'd0);
    chk("halt_nchars", 32'(seen), 32'd1);
    chk("halt_char_a", 32'(last_ch), 32'h41);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd1);
    chk("halt_no_valid", 32'(ch_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("halt_rst_halted", 32'(halted), 32'd0);
    chk("halt_rst_ready", 32'(req_ready), 32'd1);
    chk("halt_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
